// File: rtl/split_unpack_pkg.sv
// Shared field geometry for the jump/branch-target pack and unpack paths.
// Both sides import these constants so the split point can never disagree.
package split_unpack_pkg;

  localparam int W    = 32;
  localparam int HI_W = 4;
  localparam int LO_W = W - HI_W;

  typedef struct packed {
    logic [HI_W-1:0] hi;
    logic [LO_W-1:0] lo;
  } split_word_t;

endpackage

// File: rtl/split_unpack_sync_fifo2.sv
// Two-entry FIFO with valid/ready on both sides and synchronous active-high reset.
// Ready depends only on registered occupancy; a pushed word appears one edge later.
module sync_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      // NOTE: the storage is cleared too, so stale words can never leak out after reset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: rtl/split_unpack.sv
// Buffers packed {hi,lo} target words and presents the two fields separately,
// zeroed while nothing is buffered, with a wrapping count of output handshakes.
module split_unpack
  import split_unpack_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [HI_W-1:0]  out_hi,
  output logic [LO_W-1:0]  out_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_cnt
);

  logic [W-1:0]     head_word;
  split_word_t      head;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  sync_fifo2 #(
    .WIDTH(W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_word),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (head_word),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign head   = split_word_t'(head_word);
  assign out_hi = out_valid ? head.hi : '0;
  assign out_lo = out_valid ? head.lo : '0;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (out_valid && out_ready) word_cnt_d = word_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) word_cnt_q <= '0;
    else     word_cnt_q <= word_cnt_d;
  end

  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_split_unpack.sv
// Randomized and directed bench for split_unpack against a queue-based model.
// Inputs change 1 ns after the rising edge; outputs are compared at the falling edge.
module tb_split_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_word = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  out_hi;
  logic [27:0] out_lo;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  word_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_q[$];
  int          model_cnt = 0;
  logic [31:0] obs_q[$];
  logic [31:0] sent_q[$];

  split_unpack #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_word  (in_word),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_hi   (out_hi),
    .out_lo   (out_lo),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] head;
    head = (model_q.size() > 0) ? model_q[0] : 32'h0;
    check("valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
    check("ready", {31'd0, in_ready}, {31'd0, model_q.size() < 2});
    check("hi", {28'd0, out_hi}, {28'd0, head[31:28]});
    check("lo", {4'd0, out_lo}, {4'd0, head[27:0]});
    check("cnt", {24'd0, word_cnt}, model_cnt);
  endtask

  // One clock cycle: compare against the model, then advance the model by what the edge does.
  task automatic cycle(input bit do_check = 1'b1);
    bit exp_push, exp_pop;
    @(negedge clk);
    if (do_check) check_model();
    if (!rst && out_valid && out_ready) obs_q.push_back({out_hi, out_lo});
    exp_push = in_valid && (model_q.size() < 2) && !rst;
    exp_pop  = (model_q.size() > 0) && out_ready && !rst;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      model_cnt = 0;
    end else begin
      if (exp_pop) begin
        void'(model_q.pop_front());
        model_cnt = (model_cnt + 1) % 256;
      end
      if (exp_push) model_q.push_back(in_word);
    end
    #1;
  endtask

  task automatic expect_head(input string tag, input logic [3:0] hi, input logic [27:0] lo);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_hi"}, {28'd0, out_hi}, {28'd0, hi});
    check({tag, "_lo"}, {4'd0, out_lo}, {4'd0, lo});
  endtask

  initial begin
    int base;

    // Reset for two cycles; outputs are unknown before the first edge.
    rst = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    rst = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_hi", {28'd0, out_hi}, 32'd0);
    check("rst_lo", {4'd0, out_lo}, 32'd0);
    check("rst_cnt", {24'd0, word_cnt}, 32'd0);

    // Single push with the consumer stalled; head holds for 5 cycles.
    in_word  = 32'hF33FFFF0;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    in_word  = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      expect_head("stall", 4'hF, 28'h33FFFF0);
      cycle();
    end

    // Fill to two, then a third word must be refused.
    in_word  = 32'h13FFFFFC;
    in_valid = 1'b1;
    cycle();
    check("full_ready", {31'd0, in_ready}, 32'd0);
    in_word = 32'hA0000001;
    cycle();
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    expect_head("drain0", 4'hF, 28'h33FFFF0);
    cycle();
    expect_head("drain1", 4'h1, 28'h3FFFFFC);
    cycle();
    check("drain_empty", {31'd0, out_valid}, 32'd0);
    check("drain_cnt", {24'd0, word_cnt}, 32'd2);

    // Sixteen back-to-back words with the consumer always ready.
    obs_q.delete();
    sent_q.delete();
    base = model_cnt;
    for (int i = 0; i < 16; i++) begin
      in_word  = $urandom();
      in_valid = 1'b1;
      sent_q.push_back(in_word);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();
    check("stream_len", obs_q.size(), 32'd16);
    for (int i = 0; i < 16 && i < obs_q.size(); i++)
      check($sformatf("stream_w%0d", i), obs_q[i], sent_q[i]);
    check("stream_cnt", {24'd0, word_cnt}, (base + 16) % 256);

    // Reset with two words buffered; neither may ever be delivered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_word   = 32'h5555AAAA;
    cycle();
    in_word   = 32'h6666BBBB;
    cycle();
    in_valid  = 1'b0;
    rst       = 1'b1;
    out_ready = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_cnt", {24'd0, word_cnt}, 32'd0);
    obs_q.delete();
    for (int i = 0; i < 4; i++) cycle();
    check("midrst_nodata", obs_q.size(), 32'd0);

    // Handshake counter wrap: first cycle only pushes, then one pop per cycle.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      in_word = $urandom();
      cycle();
    end
    check("wrap_255", {24'd0, word_cnt}, 32'd255);
    cycle();
    check("wrap_0", {24'd0, word_cnt}, 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      in_word   = $urandom();
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      rst       = $urandom_range(0, 63) == 0;
      cycle();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
